program_loader: RTL
===================

# program_loader

Byte-stream program loader that fills the instruction memory of the pipelined CPU before execution starts. It accepts bytes over a valid/ready handshake and assembles them little-endian into 32-bit instructions. Each complete word is written into instruction memory at consecutive word addresses, and the CPU is held in reset until the program is fully loaded. It is the write side of the instruction-memory port that the CPU fetch stage reads.

## Interface

Parameters:
- `DEPTH_WORDS`, default 256: instruction-memory capacity in 32-bit words. Must be a power of two, ≥ 4.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low. 0 forces every register to its reset value immediately.
- `in_valid`  in  1  byte source has a byte on `in_byte`.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `in_byte`  in  8  program byte.
- `in_last`  in  1  qualifies `in_byte` as the final byte of the program.
- `imem_we`  out  1  one-cycle instruction-memory write strobe.
- `imem_addr`  out  64  byte address of the write; always a multiple of 4.
- `imem_wdata`  out  32  instruction word to write.
- `cpu_hold`  out  1  active-high reset to the CPU; high until the load completes.
- `done`  out  1  load finished successfully; sticky.
- `error`  out  1  load aborted; sticky.
- `words_loaded`  out  16  count of words written, including the terminator word when that feature is enabled.

## Operation

- States: LOAD, WRITE, TERM, DONE, ERR. Reset state is LOAD.
- **LOAD**
  - `in_ready` = 1.
  - A transfer occurs on any edge where `in_valid && in_ready`.
  - Byte k of a word (k = 0..3, tracked by a 2-bit byte counter) goes to `word[8k+7:8k]`.
  - After the 4th byte, go to WRITE. Latch `last_pending` = `in_last` of that byte.
  - If `in_last` arrives on byte 0, 1 or 2 (partial word), go to ERR. No write occurs.
  - If a byte is offered with `in_valid` while `word_idx == DEPTH_WORDS`, go to ERR (overflow). The byte is accepted and discarded.
- **WRITE**
  - `in_ready` = 0.
  - `imem_we` = 1, `imem_addr` = `word_idx*4`, `imem_wdata` = assembled word.
  - Increment `word_idx` and `words_loaded`; clear the byte counter.
  - Next state: DONE if `last_pending`, otherwise LOAD. The TERM rule under Configuration takes precedence when the feature is enabled.
- **TERM**: only exists when the feature macro is defined (see Configuration).
- **DONE**: `done` = 1, `cpu_hold` = 0, `in_ready` = 0. Incoming bytes are ignored. Only `reset` leaves this state.
- **ERR**: `error` = 1, `cpu_hold` = 1, `in_ready` = 0. Incoming bytes are ignored. Only `reset` leaves this state.
- Width rules:
  - `word_idx` is clog2(DEPTH_WORDS)+1 bits, so it reaches DEPTH_WORDS without wrapping.
  - `imem_addr` is `word_idx` zero-extended to 64 bits, then shifted left by 2.
  - `words_loaded` saturates at 16'hFFFF.

## Timing

- Reset values:
  - `in_ready` = 0 while `reset` = 0, then 1 from the first cycle after reset release.
  - `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `cpu_hold` = 1, `done` = 0, `error` = 0, `words_loaded` = 0.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid`/`in_last` to any output.
- Latency:
  - 4th byte accepted on edge N → `imem_we` high during cycle N..N+1. `in_ready` is low in that same cycle.
  - Peak throughput is 4 bytes per 5 cycles.
- Completion: `done` rises and `cpu_hold` falls on the same edge, one cycle after the final write strobe.
- Source gaps (`in_valid` low) stall assembly indefinitely. Partial-word contents are held.
- Reset mid-load: all state clears asynchronously. Any in-progress word is lost. Memory contents are not erased.

## Configuration

- `PROGRAM_LOADER_TERMINATE_EN`
  - **Defined**: after the write for the last word, enter TERM instead of DONE.
    - TERM issues one extra write of 32'h0000_0000 at `word_idx*4`, increments `word_idx` and `words_loaded`, then goes to DONE.
    - This places the zero word the CPU treats as end-of-program.
    - If `word_idx == DEPTH_WORDS` on entry to TERM, go to ERR with no write.
  - **Undefined**: the TERM state does not exist. The last word goes directly to DONE, and the program source is responsible for its own zero terminator.

## Test plan

- Bytes 13,00,10,00, B3,00,00,00 (`in_last` on the 8th), with `in_valid` held high:
  - writes 0x00100013 @ 0x0 and 0x000000B3 @ 0x4, five cycles apart;
  - `done`=1, `cpu_hold`=0, `words_loaded`=2 (3 and an extra zero write @ 0x8 with the macro defined).
- Backpressure: the same 8 bytes with `in_valid` toggling every other cycle → identical writes and data; no byte lost or duplicated; `in_ready`=0 exactly in WRITE cycles.
- Partial word: 3 bytes with `in_last` on the 3rd → `error`=1, no `imem_we` pulse, `cpu_hold` stays 1, `words_loaded`=0.
- Overflow with `DEPTH_WORDS`=4: 17 bytes, no `in_last` → four writes @ 0x0–0xC, then `error`=1 on acceptance of byte 17.
- Reset mid-load: pull `reset` low after 6 bytes, release, send 4 bytes with `in_last` → one write of the new word @ 0x0; `words_loaded`=1 (2 with the macro defined).
- After `done`: drive `in_valid`=1 for 10 cycles → `in_ready`=0 throughout, no writes, all outputs unchanged.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream loader: assembles little-endian 32-bit words and writes them to imem, holding the CPU in reset until done.
// Write strobe one cycle after the 4th byte (4 bytes / 5 cycles); not ready during writes; optional zero terminator via PROGRAM_LOADER_TERMINATE_EN.
module program_loader #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam int IW = $clog2(DEPTH_WORDS) + 1;
  localparam logic [IW-1:0] FULL = IW'(DEPTH_WORDS);

`ifdef PROGRAM_LOADER_TERMINATE_EN
  typedef enum logic [2:0] {S_LOAD, S_WRITE, S_TERM, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_LOAD, S_WRITE, S_DONE, S_ERR} state_t;
`endif

  state_t          state, state_nxt;
  logic            ready_en;
  logic [1:0]      byte_cnt;
  logic [31:0]     word;
  logic            last_pending;
  logic [IW-1:0]   word_idx;
  logic [15:0]     wl_cnt;
  logic            take;
  logic            bump;
  logic [31:0]     wr_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    imem_we   = 1'b0;
    wr_data   = 32'h0;
    take      = 1'b0;
    bump      = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = ready_en;
        if (in_valid && ready_en) begin
          // Overflow byte is consumed but never stored.
          if (word_idx == FULL)
            state_nxt = S_ERR;
          else if (in_last && byte_cnt != 2'd3)
            state_nxt = S_ERR;
          else begin
            take = 1'b1;
            if (byte_cnt == 2'd3) state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        imem_we = 1'b1;
        wr_data = word;
        bump    = 1'b1;
`ifdef PROGRAM_LOADER_TERMINATE_EN
        state_nxt = last_pending ? S_TERM : S_LOAD;
`else
        state_nxt = last_pending ? S_DONE : S_LOAD;
`endif
      end
`ifdef PROGRAM_LOADER_TERMINATE_EN
      S_TERM: begin
        if (word_idx == FULL)
          state_nxt = S_ERR;
        else begin
          imem_we   = 1'b1;
          bump      = 1'b1;
          state_nxt = S_DONE;
        end
      end
`endif
      default: state_nxt = state;
    endcase
  end

  assign imem_wdata   = wr_data;
  assign imem_addr    = imem_we ? (64'(word_idx) << 2) : 64'h0;
  assign cpu_hold     = (state != S_DONE);
  assign done         = (state == S_DONE);
  assign error        = (state == S_ERR);
  assign words_loaded = wl_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en     <= 1'b0;
      byte_cnt     <= 2'd0;
      word         <= 32'h0;
      last_pending <= 1'b0;
      word_idx     <= '0;
      wl_cnt       <= 16'h0;
    end else begin
      ready_en <= 1'b1;
      if (take) begin
        word[{byte_cnt, 3'b000} +: 8] <= in_byte;
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) last_pending <= in_last;
      end
      if (bump) begin
        word_idx <= word_idx + 1'b1;
        byte_cnt <= 2'd0;
        if (wl_cnt != 16'hFFFF) wl_cnt <= wl_cnt + 16'd1;
      end
    end
  end

endmodule
